// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared constants, FSM encoding and LFSR step for the enemy spawn scheduler.
package enemy_spawn_scheduler_pkg;

    localparam int COORD_W = 10;
    localparam int IDX_W   = 4;

    localparam int DEFAULT_MAX_ENEMIES = 10;
    localparam int DEFAULT_SCREEN_W    = 640;
    localparam int DEFAULT_SCREEN_H    = 480;
    localparam int DEFAULT_ENEMY_SIZE  = 20;

    localparam logic [9:0] DEFAULT_LFSR_SEED = 10'h280;
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        PLACE_X = 2'd2,
        PLACE_Y = 2'd3
    } spawn_state_t;

    // Fibonacci step with taps 10,7; never maps a non-zero state to zero.
    function automatic logic [9:0] lfsr_step(input logic [9:0] q);
        return {q[8:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/enemy_spawn_scheduler_lfsr10.sv
// Free-running 10-bit maximal-length LFSR used as the spawn position source.
module lfsr10
    import enemy_spawn_scheduler_pkg::*;
#(
    parameter logic [9:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Enemy slot table: rate-limited round-robin spawner with rejection-sampled
// on-screen positions, plus kill handling from the collision logic.
module enemy_spawn_scheduler
    import enemy_spawn_scheduler_pkg::*;
#(
    parameter int         MAX_ENEMIES  = DEFAULT_MAX_ENEMIES,
    parameter int         SPAWN_PERIOD = 25000000,
    parameter int         SCREEN_W     = DEFAULT_SCREEN_W,
    parameter int         SCREEN_H     = DEFAULT_SCREEN_H,
    parameter int         ENEMY_SIZE   = DEFAULT_ENEMY_SIZE,
    parameter logic [9:0] LFSR_SEED    = DEFAULT_LFSR_SEED
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           kill_valid,
    input  logic [IDX_W-1:0]               kill_idx,
    output logic [MAX_ENEMIES-1:0]         enemy_active,
    output logic [COORD_W*MAX_ENEMIES-1:0] enemy_x,
    output logic [COORD_W*MAX_ENEMIES-1:0] enemy_y,
    output logic [IDX_W-1:0]               active_count,
    output logic                           spawn_pulse,
    output logic [IDX_W-1:0]               spawn_slot,
    output logic                           spawn_dropped,
    output logic                           kill_ack
);

    localparam int                  TIMER_W    = $clog2(SPAWN_PERIOD);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(SPAWN_PERIOD - 1);
    localparam logic [COORD_W-1:0]  X_LIMIT    = COORD_W'(SCREEN_W - ENEMY_SIZE);
    localparam logic [8:0]          Y_LIMIT    = 9'(SCREEN_H - ENEMY_SIZE);
    localparam logic [IDX_W-1:0]    LAST_SLOT  = IDX_W'(MAX_ENEMIES - 1);
    localparam logic [IDX_W-1:0]    SLOT_COUNT = IDX_W'(MAX_ENEMIES);

    logic [9:0]             lfsr_q;
    logic [TIMER_W-1:0]     timer;
    logic                   timer_wrap;
    logic                   pending;
    spawn_state_t           state, state_next;
    logic [IDX_W-1:0]       scan_idx, scan_cnt, target_slot, rr_ptr;
    logic [COORD_W-1:0]     x_latch;
    logic                   take_pending, advance_scan, latch_slot, latch_x, place, drop;
    logic                   kill_hit;
    logic [MAX_ENEMIES-1:0] active_next;
    logic [IDX_W-1:0]       count_next;

    lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // A wrap while a spawn is still pending simply merges into it.
    assign timer_wrap = enable && (timer == TIMER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer   <= '0;
            pending <= 1'b0;
        end else begin
            if (enable) begin
                timer <= timer_wrap ? '0 : timer + 1'b1;
            end
            if (timer_wrap) begin
                pending <= 1'b1;
            end else if (take_pending) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        take_pending = 1'b0;
        advance_scan = 1'b0;
        latch_slot   = 1'b0;
        latch_x      = 1'b0;
        place        = 1'b0;
        drop         = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    take_pending = 1'b1;
                    state_next   = SEARCH;
                end
            end
            SEARCH: begin
                if (scan_cnt == SLOT_COUNT) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end else if (!enemy_active[scan_idx]) begin
                    latch_slot = 1'b1;
                    state_next = PLACE_X;
                end else begin
                    advance_scan = 1'b1;
                end
            end
            // Rejection sampling keeps the distribution uniform without a divider.
            PLACE_X: begin
                if (lfsr_q < X_LIMIT) begin
                    latch_x    = 1'b1;
                    state_next = PLACE_Y;
                end
            end
            PLACE_Y: begin
                if (lfsr_q[8:0] < Y_LIMIT) begin
                    place      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx    <= '0;
            scan_cnt    <= '0;
            target_slot <= '0;
            x_latch     <= '0;
            rr_ptr      <= '0;
        end else begin
            if (take_pending) begin
                scan_idx <= rr_ptr;
                scan_cnt <= '0;
            end else if (advance_scan) begin
                scan_idx <= (scan_idx == LAST_SLOT) ? '0 : scan_idx + 1'b1;
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (latch_slot) begin
                target_slot <= scan_idx;
            end
            if (latch_x) begin
                x_latch <= lfsr_q;
            end
            if (place) begin
                rr_ptr <= (target_slot == LAST_SLOT) ? '0 : target_slot + 1'b1;
            end
        end
    end

    // The placement target is always inactive, so it never collides with a kill.
    always_comb begin
        active_next = enemy_active;
        kill_hit    = 1'b0;
        if (kill_valid && (kill_idx < SLOT_COUNT)) begin
            kill_hit = enemy_active[kill_idx];
        end
        if (kill_hit) begin
            active_next[kill_idx] = 1'b0;
        end
        if (place) begin
            active_next[target_slot] = 1'b1;
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < MAX_ENEMIES; i++) begin
            count_next = count_next + IDX_W'(active_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enemy_active  <= '0;
            enemy_x       <= '0;
            enemy_y       <= '0;
            active_count  <= '0;
            spawn_pulse   <= 1'b0;
            spawn_slot    <= '0;
            spawn_dropped <= 1'b0;
            kill_ack      <= 1'b0;
        end else begin
            enemy_active  <= active_next;
            active_count  <= count_next;
            spawn_pulse   <= place;
            spawn_dropped <= drop;
            kill_ack      <= kill_hit;
            if (place) begin
                spawn_slot <= target_slot;
            end
            for (int i = 0; i < MAX_ENEMIES; i++) begin
                if (place && (target_slot == IDX_W'(i))) begin
                    enemy_x[i*COORD_W +: COORD_W] <= x_latch;
                    enemy_y[i*COORD_W +: COORD_W] <= {1'b0, lfsr_q[8:0]};
                end
            end
        end
    end

endmodule
